// File: rtl/rr_req_queue_bank_if.sv
// Bundle between the client ports, the round-robin arbiter and the shared output channel.
// The master drives pushes, grants and out_ready; the slave is the queue bank.
interface rr_req_queue_bank_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]   push;
    logic [N*W-1:0] push_data;
    logic [N-1:0]   full;
    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [IDW-1:0] out_id;
    logic           out_ready;
    logic [N-1:0]   overflow_err;
    logic           grant_err;

    modport master (
        output push, push_data, grant, out_ready,
        input  full, req, out_valid, out_data, out_id, overflow_err, grant_err
    );

    modport slave (
        input  push, push_data, grant, out_ready,
        output full, req, out_valid, out_data, out_id, overflow_err, grant_err
    );
endinterface

// File: rtl/rr_req_queue_bank.sv
// Per-client request FIFOs feeding a round-robin arbiter; granted head goes to one registered output.
// Grant-to-out_valid latency 1 cycle; out_ready low holds the output slot and stalls all pops.
module rr_req_queue_bank #(
    parameter  int N     = 4,
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int IDW   = $clog2(N)
) (
    input  logic              clk,
    input  logic              reset,
    rr_req_queue_bank_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem    [N][DEPTH];
    logic [PW-1:0] wr_ptr [N];
    logic [PW-1:0] rd_ptr [N];
    logic [CW-1:0] count  [N];

    logic [N-1:0]   req_vec;
    logic [N-1:0]   full_vec;
    logic [N-1:0]   push_ok;
    logic [N-1:0]   pop_vec;
    logic [IDW-1:0] pop_idx;
    logic           slot_free;
    logic           multi_hot;
    logic           grant_bad;
    logic           pop_vld;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_vec[i]  = (count[i] != '0);
            full_vec[i] = (count[i] == FULL_CNT);
        end
    end

    assign bus.req  = req_vec;
    assign bus.full = full_vec;

    assign slot_free = !bus.out_valid || bus.out_ready;
    assign multi_hot = (bus.grant & (bus.grant - 1'b1)) != '0;
    // A one-hot grant to an empty client is caught by the same term that blocks its pop.
    assign grant_bad = multi_hot || ((bus.grant & ~req_vec) != '0);
    assign pop_vld   = (bus.grant != '0) && !grant_bad && slot_free;
    assign pop_vec   = pop_vld ? bus.grant : '0;

    always_comb begin
        pop_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.grant[i]) pop_idx = IDW'(i);
        end
    end

    // A full FIFO still accepts when its head leaves on the same edge.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            push_ok[i] = bus.push[i] && (!full_vec[i] || pop_vec[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (push_ok[i]) mem[i][wr_ptr[i]] <= bus.push_data[i*W +: W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop_vec[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
                case ({push_ok[i], pop_vec[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_id    <= '0;
        end else if (slot_free) begin
            bus.out_valid <= pop_vld;
            if (pop_vld) begin
                bus.out_data <= mem[pop_idx][rd_ptr[pop_idx]];
                bus.out_id   <= pop_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.overflow_err <= '0;
            bus.grant_err    <= 1'b0;
        end else begin
            bus.overflow_err <= bus.overflow_err | (bus.push & ~push_ok);
            bus.grant_err    <= bus.grant_err | ((bus.grant != '0) && grant_bad);
        end
    end
endmodule

// File: tb/tb_rr_req_queue_bank.sv
// Randomized bench for rr_req_queue_bank: a queue-based reference model predicts pops into a
// scoreboard that an independent negedge monitor drains against the output channel.
module tb_rr_req_queue_bank;
    localparam int N     = 4;
    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int IDW   = $clog2(N);

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rr_req_queue_bank_if #(.N(N), .W(W)) bus ();

    rr_req_queue_bank #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Reference model: one queue per client plus the output slot state.
    logic [W-1:0]       mq [N][$];
    logic [IDW+W-1:0]   exp_q [$];
    logic               m_ov;
    logic [N-1:0]       m_ovf;
    logic               m_gerr;
    logic               started = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) mq[i].delete();
        exp_q.delete();
        m_ov   = 1'b0;
        m_ovf  = '0;
        m_gerr = 1'b0;
    endtask

    // Applies the inputs that were stable across the edge just taken.
    task automatic model_edge();
        int  ones;
        int  idx;
        bit  slot_free;
        bit  pop;
        logic [W-1:0] v;
        if (reset) begin
            model_clear();
            return;
        end
        ones = $countones(bus.grant);
        idx  = 0;
        for (int i = 0; i < N; i++) if (bus.grant[i]) idx = i;
        slot_free = !m_ov || bus.out_ready;
        if (ones > 1) m_gerr = 1'b1;
        if (ones == 1 && mq[idx].size() == 0) m_gerr = 1'b1;
        pop = (ones == 1) && (mq[idx].size() != 0) && slot_free;
        if (slot_free) begin
            m_ov = pop;
            if (pop) begin
                v = mq[idx].pop_front();
                exp_q.push_back({IDW'(idx), v});
            end
        end
        for (int i = 0; i < N; i++) begin
            if (bus.push[i]) begin
                if (mq[i].size() < DEPTH) mq[i].push_back(bus.push_data[i*W +: W]);
                else m_ovf[i] = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic drive(input int pp, input int gp, input int rp, input int ep);
        int r;
        int cand [$];
        for (int i = 0; i < N; i++) bus.push[i] = ($urandom_range(99) < pp);
        for (int i = 0; i < N; i++) bus.push_data[i*W +: W] = W'($urandom);
        r = $urandom_range(99);
        bus.grant = '0;
        if (r < ep) begin
            bus.grant = N'($urandom);
        end else if (r < ep + gp) begin
            for (int i = 0; i < N; i++) if (mq[i].size() != 0) cand.push_back(i);
            if (cand.size() != 0) bus.grant[cand[$urandom_range(cand.size() - 1)]] = 1'b1;
        end
        bus.out_ready = ($urandom_range(99) < rp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.push = 4'b0001;
        bus.push_data = '1;
        bus.grant = '0;
        bus.out_ready = 1'b0;
        model_clear();
        started = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        bus.push = '0;
    endtask

    // Monitor: flags every cycle, and output payload against the scoreboard head.
    always @(negedge clk) begin
        logic [N-1:0] e_req;
        logic [N-1:0] e_full;
        logic [IDW+W-1:0] head;
        if (started) begin
            for (int i = 0; i < N; i++) begin
                e_req[i]  = (mq[i].size() != 0);
                e_full[i] = (mq[i].size() == DEPTH);
            end
            check("req", 32'(bus.req), 32'(e_req));
            check("full", 32'(bus.full), 32'(e_full));
            check("out_valid", 32'(bus.out_valid), 32'(m_ov));
            check("overflow_err", 32'(bus.overflow_err), 32'(m_ovf));
            check("grant_err", 32'(bus.grant_err), 32'(m_gerr));
            if (bus.out_valid && !reset) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", 32'(bus.out_valid), 32'(0));
                end else begin
                    head = exp_q[0];
                    check("out_id", 32'(bus.out_id), 32'(head[IDW+W-1:W]));
                    check("out_data", 32'(bus.out_data), 32'(head[W-1:0]));
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int pp [5] = '{30, 80, 50, 40, 60};
        int gp [5] = '{60, 20, 80, 50, 40};
        int rp [5] = '{90, 50, 30, 70, 20};
        int ep [5] = '{ 0,  0,  0, 10, 20};
        bus.push = '0;
        bus.push_data = '0;
        bus.grant = '0;
        bus.out_ready = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        for (int ph = 0; ph < 5; ph++) begin
            do_reset();
            for (int c = 0; c < 300; c++) begin
                drive(pp[ph], gp[ph], rp[ph], ep[ph]);
                step();
            end
        end
        for (int c = 0; c < 60; c++) begin
            drive(0, 100, 100, 0);
            step();
        end
        bus.grant = '0;
        bus.out_ready = 1'b1;
        step();
        step();
        check("drain_empty", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rr_req_queue_bank.md
Name: rr_req_queue_bank

Overview:
- Upstream feeder for the round-robin arbiter: one request FIFO per client.
- Drives the arbiter's `req` vector from FIFO occupancy.
- Consumes the arbiter's one-hot `grant` to pop the granted client's head entry onto a single shared output channel with valid/ready handshake.
- Sits between the N client ports and the shared downstream resource.

Parameters:
- N, 4, number of clients; must match the arbiter's N.
- W, 8, payload width per entry, in bits.
- DEPTH, 4, entries per client FIFO; power of two, at least 2.
- IDW, $clog2(N), width of the client-id output; derived, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- push  input  N  per-client write strobe.
- push_data  input  N*W  per-client payload; client i occupies bits [i*W +: W].
- full  output  N  full[i] = count[i]==DEPTH.
- req  output  N  to arbiter; req[i] = count[i]!=0.
- grant  input  N  from arbiter; expected one-hot or zero.
- out_valid  output  1  registered output holds a valid entry.
- out_data  output  W  registered payload.
- out_id  output  IDW  index of the client that supplied out_data.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- overflow_err  output  N  sticky; push attempted while the FIFO is full with no pop that cycle.
- grant_err  output  1  sticky; grant multi-hot, or grant to a client with count 0.

Behaviour:
Reset:
- Asynchronous assertion clears all FIFO pointers and counts.
- Clears out_valid, out_data, out_id, overflow_err and grant_err to 0.
- Resulting outputs: req=0, full=0.
- FIFO contents are don't-care.
- Reset mid-operation discards all queued and in-flight entries; nothing is replayed.

Storage:
- Per client: wr_ptr and rd_ptr of $clog2(DEPTH) bits, both wrapping modulo DEPTH.
- count is $clog2(DEPTH+1) bits.
- req and full are combinational from the registered count only.
- A push into an empty FIFO raises req[i] on the cycle after the push edge.

Output-slot rule:
- slot_free = !out_valid || out_ready.

Pop rule (evaluated each cycle):
- Pop client i iff grant[i]=1, grant is one-hot, count[i]!=0, and slot_free.
- On pop, at the next edge: out_data <= head of FIFO i, out_id <= i, out_valid <= 1, rd_ptr[i] increments, count[i] decrements.
- Latency from grant to out_valid is 1 cycle.
- At most one pop per cycle.

Output hold:
- If slot_free and no pop occurs, out_valid <= 0.
- If out_valid && !out_ready, out_valid/out_data/out_id hold and no pop occurs, even with grant present (backpressure stalls the queue; the arbiter may keep granting).

Push rule:
- Push to client i is accepted iff count[i]<DEPTH, or a pop of client i occurs in the same cycle.
- Simultaneous push and pop on the same client leaves count unchanged and advances both pointers.
- A rejected push drops the data and sets overflow_err[i].
- Push on an empty FIFO with grant[i] present in the same cycle does not pop; req is not yet visible.

Error detection:
- grant_err sets if $countones(grant)>1, or grant[i]=1 with count[i]=0; no pop occurs that cycle.
- grant=0 is legal and idle.
- Sticky errors clear only on reset.

Ordering:
- Per-client FIFO order is preserved.
- Cross-client order is defined solely by grant.

Test Plan:
1. Reset with push=0001 held → after reset release, full=0, req=0000, out_valid=0; overflow_err=0 and grant_err=0.
2. Push 0xA1, 0xA2 into client 2; drive grant=0100 from the cycle after req[2] rises, with out_ready=1 → out_valid on consecutive cycles with out_data 0xA1 then 0xA2, out_id=2; then req=0000, out_valid=0.
3. Fill client 0 with 4 entries → full=0001; a 5th push with no grant is dropped and overflow_err=0001. A 5th push in the same cycle as grant=0001 is accepted, count stays 4, and the order is preserved.
4. Queue entries on clients 0, 1 and 3 (req=1011); apply grants 0001, 0010, 1000 in sequence → out_id 0, 1, 3 with the matching payloads in order.
5. out_ready=0 while out_valid=1 and grant=0010 is held for 3 cycles → out_data is stable, count[1] is unchanged, no pop. Raising out_ready → next entry appears on the following cycle.
6. grant=0110 with both queues non-empty → no pop, grant_err=1. Separately, grant=0001 with count[0]=0 → grant_err=1. Assert reset mid-stream → all counts, errors and out_valid return to 0.
